// File: rtl/timing_mp.sv
// timing_mp: radar CPI/PRI/TX/sample-gate timing generator with double-buffered configuration.
// Optional feature macro FIRST_CHIRP_BLANK_EN: blank the sample gates on chirp 0 when first_chirp_disable is set.
module timing_mp #(
    parameter int PER_W      = 16,
    parameter int NUM_W      = 8,
    parameter int DLY_W      = 32,
    parameter int NGATE      = 2,
    parameter int DEF_PERIOD = 5275,
    parameter int DEF_NUM    = 32,
    parameter int DEF_WIDTH  = 50,
    parameter int DEF_DELAY  = 750,
    parameter int DEF_START  = 1000,
    parameter int DEF_LEN    = 4125,
    parameter int DEF_TXLEN  = 5127
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   abort,
    input  logic                   cfg_wr,
    input  logic [PER_W-1:0]       cfg_period,
    input  logic [NUM_W-1:0]       cfg_num,
    input  logic [PER_W-1:0]       cfg_width,
    input  logic [DLY_W-1:0]       cfg_delay,
    input  logic [PER_W-1:0]       cfg_txlen,
    input  logic [NGATE*PER_W-1:0] cfg_gate_start,
    input  logic [NGATE*PER_W-1:0] cfg_gate_len,
    input  logic                   first_chirp_disable,
    output logic                   pri,
    output logic                   cpib,
    output logic                   cpie,
    output logic                   tx_en,
    output logic [NGATE-1:0]       sample_gate,
    output logic [NUM_W-1:0]       chirp_idx,
    output logic [15:0]            cpi_cnt,
    output logic                   cfg_pend,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DLY  = 2'd2
    } state_t;

    function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
        if (p < PER_W'(2'd2)) begin
            return PER_W'(2'd2);
        end else begin
            return p;
        end
    endfunction

    function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] n);
        if (n == NUM_W'(1'b0)) begin
            return NUM_W'(1'b1);
        end else begin
            return n;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [PER_W-1:0]       pcnt_q, pcnt_d;
    logic [NUM_W-1:0]       ccnt_q, ccnt_d;
    logic [DLY_W-1:0]       dcnt_q, dcnt_d;
    logic                   cpi_start_s;

    logic [PER_W-1:0]       sh_period_q, sh_width_q, sh_txlen_q;
    logic [NUM_W-1:0]       sh_num_q;
    logic [DLY_W-1:0]       sh_delay_q;
    logic [NGATE*PER_W-1:0] sh_gstart_q, sh_glen_q;
    logic                   pend_q;

    logic [PER_W-1:0]       act_period_q, act_width_q, act_txlen_q;
    logic [NUM_W-1:0]       act_num_q;
    logic [DLY_W-1:0]       act_delay_q;
    logic [NGATE*PER_W-1:0] act_gstart_q, act_glen_q;

    logic                   run_s, last_pcnt_s, last_chirp_s, blank_s;
    logic                   pri_s, cpib_s, cpie_s, tx_s;
    logic [NGATE-1:0]       gate_s;

    logic                   pri_q, cpib_q, cpie_q, tx_q, busy_q;
    logic [NGATE-1:0]       gate_q;
    logic [NUM_W-1:0]       chirp_q;
    logic [15:0]            cpi_cnt_q;

    assign last_pcnt_s  = (pcnt_q == (act_period_q - PER_W'(1'b1)));
    assign last_chirp_s = (ccnt_q == (act_num_q - NUM_W'(1'b1)));
    assign run_s        = (state_q == S_RUN);

    // Next-state and counter logic; abort overrides everything
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        ccnt_d      = ccnt_q;
        dcnt_d      = dcnt_q;
        cpi_start_s = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            ccnt_d  = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pcnt_d = '0;
                    ccnt_d = '0;
                    dcnt_d = '0;
                    if (en) begin
                        state_d     = S_RUN;
                        cpi_start_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (last_pcnt_s) begin
                        pcnt_d = '0;
                        if (!last_chirp_s) begin
                            ccnt_d = ccnt_q + NUM_W'(1'b1);
                        end else if (act_delay_q != DLY_W'(1'b0)) begin
                            state_d = S_DLY;
                            dcnt_d  = '0;
                        end else if (en) begin
                            ccnt_d      = '0;
                            cpi_start_s = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            ccnt_d  = '0;
                        end
                    end else begin
                        pcnt_d = pcnt_q + PER_W'(1'b1);
                    end
                end
                S_DLY: begin
                    if (dcnt_q == (act_delay_q - DLY_W'(1'b1))) begin
                        dcnt_d = '0;
                        ccnt_d = '0;
                        if (en) begin
                            state_d     = S_RUN;
                            cpi_start_s = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        dcnt_d = dcnt_q + DLY_W'(1'b1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                    ccnt_d  = '0;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            ccnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ccnt_q  <= ccnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Shadow set: a write coinciding with a CPI start stays pending for the next one
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            sh_period_q <= PER_W'(DEF_PERIOD);
            sh_num_q    <= NUM_W'(DEF_NUM);
            sh_width_q  <= PER_W'(DEF_WIDTH);
            sh_delay_q  <= DLY_W'(DEF_DELAY);
            sh_txlen_q  <= PER_W'(DEF_TXLEN);
            sh_gstart_q <= {NGATE{PER_W'(DEF_START)}};
            sh_glen_q   <= {NGATE{PER_W'(DEF_LEN)}};
            pend_q      <= 1'b0;
        end else if (cfg_wr) begin
            sh_period_q <= cfg_period;
            sh_num_q    <= cfg_num;
            sh_width_q  <= cfg_width;
            sh_delay_q  <= cfg_delay;
            sh_txlen_q  <= cfg_txlen;
            sh_gstart_q <= cfg_gate_start;
            sh_glen_q   <= cfg_gate_len;
            pend_q      <= 1'b1;
        end else if (cpi_start_s) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_q;
        end
    end

    // Active set, loaded atomically from the pre-edge shadow at every CPI start
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            act_period_q <= PER_W'(DEF_PERIOD);
            act_num_q    <= NUM_W'(DEF_NUM);
            act_width_q  <= PER_W'(DEF_WIDTH);
            act_delay_q  <= DLY_W'(DEF_DELAY);
            act_txlen_q  <= PER_W'(DEF_TXLEN);
            act_gstart_q <= {NGATE{PER_W'(DEF_START)}};
            act_glen_q   <= {NGATE{PER_W'(DEF_LEN)}};
        end else if (cpi_start_s) begin
            act_period_q <= clamp_period(sh_period_q);
            act_num_q    <= clamp_num(sh_num_q);
            act_width_q  <= sh_width_q;
            act_delay_q  <= sh_delay_q;
            act_txlen_q  <= sh_txlen_q;
            act_gstart_q <= sh_gstart_q;
            act_glen_q   <= sh_glen_q;
        end else begin
            act_period_q <= act_period_q;
        end
    end

`ifdef FIRST_CHIRP_BLANK_EN
    logic [1:0] fcd_sync_q;

    // Two-flop synchroniser for the asynchronous blanking control
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            fcd_sync_q <= 2'b00;
        end else begin
            fcd_sync_q <= {fcd_sync_q[0], first_chirp_disable};
        end
    end

    assign blank_s = fcd_sync_q[1] && (ccnt_q == NUM_W'(1'b0));
`else
    logic fcd_unused_s;
    assign fcd_unused_s = first_chirp_disable;
    assign blank_s      = 1'b0;
`endif

    // Strobe decode; the window end is summed one bit wider so it truncates at the chirp end
    always_comb begin
        pri_s  = run_s && (pcnt_q < act_width_q);
        tx_s   = run_s && (pcnt_q < act_txlen_q);
        cpib_s = run_s && (ccnt_q == NUM_W'(1'b0)) && (pcnt_q == PER_W'(1'b0));
        cpie_s = run_s && last_chirp_s && last_pcnt_s && !abort;
        gate_s = '0;
        for (int g = 0; g < NGATE; g++) begin
            if (run_s && !blank_s
                && (pcnt_q >= act_gstart_q[g*PER_W +: PER_W])
                && ({1'b0, pcnt_q} < ({1'b0, act_gstart_q[g*PER_W +: PER_W]}
                                      + {1'b0, act_glen_q[g*PER_W +: PER_W]}))) begin
                gate_s[g] = 1'b1;
            end else begin
                gate_s[g] = 1'b0;
            end
        end
    end

    // Output registers
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            pri_q     <= 1'b0;
            cpib_q    <= 1'b0;
            cpie_q    <= 1'b0;
            tx_q      <= 1'b0;
            gate_q    <= '0;
            chirp_q   <= '0;
            cpi_cnt_q <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            pri_q     <= pri_s;
            cpib_q    <= cpib_s;
            cpie_q    <= cpie_s;
            tx_q      <= tx_s;
            gate_q    <= gate_s;
            chirp_q   <= ccnt_q;
            cpi_cnt_q <= cpib_s ? (cpi_cnt_q + 16'd1) : cpi_cnt_q;
            busy_q    <= (state_q != S_IDLE);
        end
    end

    assign pri         = pri_q;
    assign cpib        = cpib_q;
    assign cpie        = cpie_q;
    assign tx_en       = tx_q;
    assign sample_gate = gate_q;
    assign chirp_idx   = chirp_q;
    assign cpi_cnt     = cpi_cnt_q;
    assign cfg_pend    = pend_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_timing_mp.sv
// Directed self-checking bench for timing_mp; sample index 0 is the cycle in which cpib is seen high.
module tb_timing_mp;
    localparam int PER_W = 16;
    localparam int NUM_W = 8;
    localparam int DLY_W = 32;
    localparam int NGATE = 2;

    logic                   sys_clk, rstn, en, abort, cfg_wr, first_chirp_disable;
    logic [PER_W-1:0]       cfg_period, cfg_width, cfg_txlen;
    logic [NUM_W-1:0]       cfg_num;
    logic [DLY_W-1:0]       cfg_delay;
    logic [NGATE*PER_W-1:0] cfg_gate_start, cfg_gate_len;
    logic                   pri, cpib, cpie, tx_en, cfg_pend, busy;
    logic [NGATE-1:0]       sample_gate;
    logic [NUM_W-1:0]       chirp_idx;
    logic [15:0]            cpi_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    timing_mp dut (
        .sys_clk(sys_clk), .rstn(rstn), .en(en), .abort(abort), .cfg_wr(cfg_wr),
        .cfg_period(cfg_period), .cfg_num(cfg_num), .cfg_width(cfg_width),
        .cfg_delay(cfg_delay), .cfg_txlen(cfg_txlen),
        .cfg_gate_start(cfg_gate_start), .cfg_gate_len(cfg_gate_len),
        .first_chirp_disable(first_chirp_disable),
        .pri(pri), .cpib(cpib), .cpie(cpie), .tx_en(tx_en), .sample_gate(sample_gate),
        .chirp_idx(chirp_idx), .cpi_cnt(cpi_cnt), .cfg_pend(cfg_pend), .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(negedge sys_clk);
    endtask

    task automatic do_cfg(input int p, input int n, input int w, input int d, input int tx,
                          input int gs0, input int gl0, input int gs1, input int gl1);
        cfg_period     = PER_W'(p);
        cfg_num        = NUM_W'(n);
        cfg_width      = PER_W'(w);
        cfg_delay      = DLY_W'(d);
        cfg_txlen      = PER_W'(tx);
        cfg_gate_start = {PER_W'(gs1), PER_W'(gs0)};
        cfg_gate_len   = {PER_W'(gl1), PER_W'(gl0)};
        cfg_wr = 1'b1;
        tick;
        cfg_wr = 1'b0;
    endtask

    task automatic wait_cpib(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick;
            n++;
            if (cpib === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic stop_run;
        abort = 1'b1;
        en    = 1'b0;
        tick;
        abort = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_reset;
        rstn = 1'b0; en = 1'b0; abort = 1'b0; cfg_wr = 1'b0; first_chirp_disable = 1'b0;
        do_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick;
        n_tests++;
        if ({pri, cpib, cpie, tx_en, sample_gate} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000000", {pri, cpib, cpie, tx_en, sample_gate});
        end
        n_tests++;
        if (chirp_idx !== 8'd0 || cpi_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: got idx=%0d cnt=%0d want 0/0", chirp_idx, cpi_cnt);
        end
        n_tests++;
        if (cfg_pend !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_pend_busy: got %b%b want 00", cfg_pend, busy);
        end
        rstn = 1'b1;
        repeat (3) tick;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_defaults;
        int n; bit ok;
        int pri_c, tx_c, g0_c, g1_c, g0_first, cpib_c;
        logic p_next; logic [NUM_W-1:0] c_next; logic [15:0] cnt0;
        pri_c = 0; tx_c = 0; g0_c = 0; g1_c = 0; g0_first = -1; cpib_c = 0;
        p_next = 1'b0; c_next = '0; cnt0 = '0;
        en = 1'b1;
        wait_cpib(10, n, ok);
        n_tests++;
        if (!ok || n != 2) begin
            n_fail++; $display("FAIL def_start_latency: got ok=%0d n=%0d want 1/2", ok, n);
        end
        for (int i = 0; i < 5400; i++) begin
            if (i > 0) tick;
            if (i < 5275) begin
                pri_c += int'(pri); tx_c += int'(tx_en);
                g0_c += int'(sample_gate[0]); g1_c += int'(sample_gate[1]);
                if (g0_first < 0 && sample_gate[0] === 1'b1) g0_first = i;
            end
            cpib_c += int'(cpib);
            if (i == 0) cnt0 = cpi_cnt;
            if (i == 5275) begin p_next = pri; c_next = chirp_idx; end
        end
        n_tests++;
        if (pri_c != 50) begin n_fail++; $display("FAIL def_pri_width: got %0d want 50", pri_c); end
        n_tests++;
        if (tx_c != 5127) begin n_fail++; $display("FAIL def_tx_len: got %0d want 5127", tx_c); end
        n_tests++;
        if (g0_first != 1000) begin n_fail++; $display("FAIL def_gate0_start: got %0d want 1000", g0_first); end
        n_tests++;
        if (g0_c != 4125 || g1_c != 4125) begin
            n_fail++; $display("FAIL def_gate_len: got %0d/%0d want 4125/4125", g0_c, g1_c);
        end
        n_tests++;
        if (p_next !== 1'b1 || c_next !== 8'd1) begin
            n_fail++; $display("FAIL def_chirp_period: got pri=%b idx=%0d want 1/1", p_next, c_next);
        end
        n_tests++;
        if (cpib_c != 1 || cnt0 !== 16'd1) begin
            n_fail++; $display("FAIL def_cpib: got count=%0d cnt=%0d want 1/1", cpib_c, cnt0);
        end
        stop_run;
    endtask

    task automatic test_double_buffer;
        int n; bit ok;
        int pri_c, tx_c, g0_c, g1_c, cpib_c, cpie_c, cpie_i;
        logic pend11, pend198, pend199, cpib199, cpib200; logic [15:0] cnt200; logic [NUM_W-1:0] idx350;
        pri_c = 0; tx_c = 0; g0_c = 0; g1_c = 0; cpib_c = 0; cpie_c = 0; cpie_i = -1;
        pend11 = 0; pend198 = 0; pend199 = 1; cpib199 = 1; cpib200 = 0; cnt200 = '0; idx350 = '0;
        do_cfg(60, 3, 10, 20, 30, 5, 10, 0, 0);
        en = 1'b1;
        wait_cpib(10, n, ok);
        n_tests++;
        if (!ok || n != 2) begin n_fail++; $display("FAIL cfgA_start: got ok=%0d n=%0d want 1/2", ok, n); end
        for (int i = 1; i <= 200; i++) begin
            if (i == 11) do_cfg(100, 4, 10, 0, 60, 20, 30, 90, 50);
            else tick;
            if (i == 11) pend11 = cfg_pend;
            if (i == 198) pend198 = cfg_pend;
            if (i == 199) begin pend199 = cfg_pend; cpib199 = cpib; end
            if (i == 200) begin cpib200 = cpib; cnt200 = cpi_cnt; end
        end
        n_tests++;
        if (pend11 !== 1'b1 || pend198 !== 1'b1 || pend199 !== 1'b0) begin
            n_fail++; $display("FAIL cfg_pend_track: got %b%b%b want 110", pend11, pend198, pend199);
        end
        n_tests++;
        if (cpib199 !== 1'b0 || cpib200 !== 1'b1 || cnt200 !== 16'd3) begin
            n_fail++; $display("FAIL old_cpi_len: got cpib199=%b cpib200=%b cnt=%0d want 0/1/3", cpib199, cpib200, cnt200);
        end
        for (int i = 0; i < 400; i++) begin
            if (i > 0) tick;
            pri_c += int'(pri); tx_c += int'(tx_en);
            g0_c += int'(sample_gate[0]); g1_c += int'(sample_gate[1]);
            cpib_c += int'(cpib); cpie_c += int'(cpie);
            if (cpie === 1'b1) cpie_i = i;
            if (i == 350) idx350 = chirp_idx;
        end
        n_tests++;
        if (pri_c != 40 || tx_c != 240) begin
            n_fail++; $display("FAIL new_pri_tx: got %0d/%0d want 40/240", pri_c, tx_c);
        end
        n_tests++;
        if (g0_c != 120 || g1_c != 40) begin
            n_fail++; $display("FAIL new_gates: got %0d/%0d want 120/40", g0_c, g1_c);
        end
        n_tests++;
        if (cpib_c != 1 || cpie_c != 1 || cpie_i != 399 || idx350 !== 8'd3) begin
            n_fail++; $display("FAIL new_cpi_marks: got cpib=%0d cpie=%0d at %0d idx=%0d want 1/1/399/3",
                               cpib_c, cpie_c, cpie_i, idx350);
        end
        tick;
        n_tests++;
        if (cpib !== 1'b1) begin n_fail++; $display("FAIL back_to_back: got %b want 1", cpib); end
    endtask

    task automatic test_en_drop;
        int n; bit ok; int cpie_c, cpie_i, cpib_c;
        logic b229, b230; logic [NUM_W-1:0] idx235;
        cpie_c = 0; cpie_i = -1; cpib_c = 0; b229 = 0; b230 = 1; idx235 = '1;
        repeat (5) tick;
        do_cfg(50, 4, 5, 30, 10, 2, 5, 0, 0);
        wait_cpib(500, n, ok);
        n_tests++;
        if (!ok || n != 394) begin n_fail++; $display("FAIL b2b_gap: got ok=%0d n=%0d want 1/394", ok, n); end
        for (int i = 1; i <= 235; i++) begin
            if (i == 111) en = 1'b0;
            tick;
            cpie_c += int'(cpie); cpib_c += int'(cpib);
            if (cpie === 1'b1) cpie_i = i;
            if (i == 229) b229 = busy;
            if (i == 230) b230 = busy;
            if (i == 235) idx235 = chirp_idx;
        end
        n_tests++;
        if (cpie_c != 1 || cpie_i != 199) begin
            n_fail++; $display("FAIL drop_cpie: got count=%0d at %0d want 1/199", cpie_c, cpie_i);
        end
        n_tests++;
        if (b229 !== 1'b1 || b230 !== 1'b0 || cpib_c != 0 || idx235 !== 8'd0) begin
            n_fail++; $display("FAIL drop_idle: got busy229=%b busy230=%b cpib=%0d idx=%0d want 1/0/0/0",
                               b229, b230, cpib_c, idx235);
        end
    endtask

    task automatic test_abort;
        int n; bit ok; int cpie_c, busy_c;
        cpie_c = 0; busy_c = 0;
        en = 1'b1;
        wait_cpib(10, n, ok);
        repeat (100) tick;
        n_tests++;
        if (!ok || pri !== 1'b1 || chirp_idx !== 8'd2 || cpi_cnt !== 16'd6) begin
            n_fail++; $display("FAIL abort_pre: got ok=%0d pri=%b idx=%0d cnt=%0d want 1/1/2/6", ok, pri, chirp_idx, cpi_cnt);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        en    = 1'b0;
        tick;
        n_tests++;
        if ({pri, tx_en, sample_gate, cpib, cpie, busy} !== 7'b0) begin
            n_fail++; $display("FAIL abort_quiet: got %b want 0000000", {pri, tx_en, sample_gate, cpib, cpie, busy});
        end
        for (int i = 0; i < 300; i++) begin
            tick;
            cpie_c += int'(cpie); busy_c += int'(busy);
        end
        n_tests++;
        if (cpie_c != 0 || busy_c != 0) begin
            n_fail++; $display("FAIL abort_no_cpie: got cpie=%0d busy=%0d want 0/0", cpie_c, busy_c);
        end
    endtask

    task automatic test_clamp;
        int n; bit ok; int cpib_c, cpie_c, pri_c, g_c;
        cpib_c = 0; cpie_c = 0; pri_c = 0; g_c = 0;
        do_cfg(1, 0, 1, 0, 1, 0, 0, 0, 0);
        en = 1'b1;
        wait_cpib(10, n, ok);
        for (int i = 1; i <= 20; i++) begin
            tick;
            cpib_c += int'(cpib); cpie_c += int'(cpie); pri_c += int'(pri);
            g_c += int'(sample_gate[0]) + int'(sample_gate[1]);
        end
        n_tests++;
        if (!ok || cpib_c != 10 || cpie_c != 10 || pri_c != 10) begin
            n_fail++; $display("FAIL clamp_chirp: got ok=%0d cpib=%0d cpie=%0d pri=%0d want 1/10/10/10",
                               ok, cpib_c, cpie_c, pri_c);
        end
        n_tests++;
        if (g_c != 0 || cfg_pend !== 1'b0) begin
            n_fail++; $display("FAIL clamp_zero_len: got gates=%0d pend=%b want 0/0", g_c, cfg_pend);
        end
        stop_run;
    endtask

    task automatic test_first_chirp;
        int n; bit ok; int g_first, g_rest, exp_first;
`ifdef FIRST_CHIRP_BLANK_EN
        exp_first = 0;
`else
        exp_first = 5;
`endif
        g_first = 0; g_rest = 0;
        first_chirp_disable = 1'b1;
        repeat (4) tick;
        do_cfg(20, 3, 1, 0, 1, 2, 5, 0, 0);
        en = 1'b1;
        wait_cpib(10, n, ok);
        for (int i = 0; i < 60; i++) begin
            if (i > 0) tick;
            if (i < 20) g_first += int'(sample_gate[0]);
            else g_rest += int'(sample_gate[0]);
        end
        n_tests++;
        if (!ok || g_first != exp_first || g_rest != 10) begin
            n_fail++; $display("FAIL first_chirp_gate: got ok=%0d chirp0=%0d rest=%0d want 1/%0d/10",
                               ok, g_first, g_rest, exp_first);
        end
        stop_run;
        first_chirp_disable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_defaults;
        test_double_buffer;
        test_en_drop;
        test_abort;
        test_clamp;
        test_first_chirp;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_mp.md
# timing_mp

Parametrised radar timing generator: the successor to the fixed single-gate CPI/PRI sequencer. It produces the CPI, PRI, TX-enable and per-channel sample-gate strobes for the RF front end and the ADC capture path. A run/stop/abort state machine controls the sequence. Configuration is double-buffered: writes land in a shadow set, and the shadow set is applied atomically at a CPI start. Sits between the PS-side register bank and the waveform/ADC capture blocks.

## Interface
Parameters:
- PER_W, 16: width of the PRI period, pulse width, gate start/length and TX length fields.
- NUM_W, 8: width of the chirps-per-CPI count and the chirp index.
- DLY_W, 32: width of the inter-CPI delay.
- NGATE, 2: number of independent sample-gate channels.
- DEF_PERIOD 5275, DEF_NUM 32, DEF_WIDTH 50, DEF_DELAY 750, DEF_START 1000, DEF_LEN 4125, DEF_TXLEN 5127: reset values of the shadow and active sets; every gate resets to DEF_START/DEF_LEN.

Ports (one clock; reset is asynchronous and active-low):
- sys_clk, in, 1: system clock, 100 MHz.
- rstn, in, 1: asynchronous active-low reset.
- en, in, 1: run request, level.
- abort, in, 1: synchronous immediate stop, pulse.
- cfg_wr, in, 1: capture all cfg_* inputs into the shadow set, one-cycle pulse.
- cfg_period, in, PER_W: PRI period in cycles.
- cfg_num, in, NUM_W: chirps per CPI.
- cfg_width, in, PER_W: PRI pulse width in cycles.
- cfg_delay, in, DLY_W: inter-CPI delay in cycles.
- cfg_txlen, in, PER_W: TX-enable length in cycles.
- cfg_gate_start, in, NGATE*PER_W: packed gate starts; gate g uses bits [g*PER_W +: PER_W].
- cfg_gate_len, in, NGATE*PER_W: packed gate lengths, same packing.
- first_chirp_disable, in, 1: blank sample gates on chirp 0 of each CPI. Acts only when FIRST_CHIRP_BLANK_EN is defined.
- pri, out, 1: PRI pulse.
- cpib, out, 1: CPI begin, one-cycle pulse.
- cpie, out, 1: CPI end, one-cycle pulse.
- tx_en, out, 1: transmit enable.
- sample_gate, out, NGATE: per-channel ADC sample window.
- chirp_idx, out, NUM_W: index of the current chirp.
- cpi_cnt, out, 16: CPI counter; increments on each cpib and wraps at 0xFFFF.
- cfg_pend, out, 1: shadow set written but not yet applied.
- busy, out, 1: state machine is not in IDLE.

## Operation
- States:
  - IDLE: counters held at 0.
  - RUN: pcnt counts 0..P-1. Each chirp wrap increments the chirp counter.
  - DLY: dcnt counts 0..D-1.
- Transitions:
  - IDLE→RUN when en=1.
  - RUN→DLY at pcnt=P-1 on chirp N-1 when D>0. If D=0, go straight to a new CPI when en=1, otherwise to IDLE.
  - DLY→RUN at dcnt=D-1 when en=1, otherwise →IDLE.
  - abort=1 forces IDLE from any state. abort has priority over en.
- CPI start is every entry into RUN at chirp 0. On that edge the shadow set is copied to the active set and cfg_pend is cleared.
- cfg_wr loads the shadow set and sets cfg_pend.
  - If cfg_wr coincides with a CPI start, the active load takes the pre-edge shadow.
  - The new write stays pending, so cfg_pend remains 1.
- Clamps, applied on load into the active set: period <2 becomes 2; num=0 becomes 1.
- Output decodes from the current state and counters, registered:
  - pri: RUN and pcnt < W.
  - tx_en: RUN and pcnt < TXLEN.
  - sample_gate[g]: RUN and start_g ≤ pcnt < start_g+len_g. The sum is computed in PER_W+1 bits, so a window running past P is truncated at the chirp end. len_g=0 keeps gate g low.
  - cpib: RUN, chirp 0, pcnt=0.
  - cpie: RUN, last chirp, pcnt=P-1.

## Timing
- Every output is registered and lags the state/counters by 1 cycle.
- Let T0 be the first RUN cycle of a CPI.
  - cpib is high in cycle T0+1.
  - pri is high in cycles T0+1..T0+W.
  - en sampled high in IDLE at cycle t gives T0=t+1, so cpib is high at t+2.
- Chirp length is exactly P cycles. CPI length is exactly N·P+D cycles.
- cpie is high for one cycle, one cycle after the last pcnt=P-1.
- en dropped mid-CPI: the current CPI and its DLY complete, then the block goes to IDLE.
- abort: state is IDLE on the next edge; all strobes are 0 one cycle later; cpie is not issued for the aborted CPI.
- Reset: every output is 0 except cpi_cnt=0 and chirp_idx=0. Shadow and active sets take the DEF_* values; cfg_pend=0.

## Configuration
- FIRST_CHIRP_BLANK_EN defined:
  - first_chirp_disable passes through a 2-flop synchroniser.
  - When the synchronised value is 1, sample_gate is forced to 0 throughout chirp 0 of every CPI.
- Not defined: first_chirp_disable is ignored and the gates run on every chirp.

## Test plan
- Defaults, en=1 from reset release → cpib period 32·5275+750=169550 cycles; pri high 50 cycles; sample_gate[0] high 4125 cycles starting 1000 cycles after each pri rise.
- cfg_wr with period=100, num=4, delay=0 written mid-CPI → the current CPI completes on the old set; the next CPI uses 400-cycle CPIs back to back; cfg_pend falls at that CPI's start.
- period=100, gate1 start=90, len=50 → gate1 high 10 cycles per chirp.
- en dropped on chirp 2 → cpie fires, DLY completes, busy=0; abort on chirp 2 → no cpie, all strobes 0 within 2 cycles.
- Clamps: num=0, period=1 → one 2-cycle chirp per CPI.
- FIRST_CHIRP_BLANK_EN defined with first_chirp_disable=1 → no sample_gate on chirp 0 and gates present on chirps 1..N-1; without the macro → gates present on all chirps.
